video_wr_sched: RTL and testbench

- Scheduler for the single Video_Mem write port.
- Two requesters share the port: the Core's video write stream (core_*) and a hardware rectangle/screen fill engine (fill_*).
- Core writes cannot be stalled, so they are buffered in a small FIFO while the memory port is busy (vm_ready low, e.g. scanout contention).
- Sits between Core and Video_Mem inside SoC; drives vm_we/vm_addr/vm_data.

---
 rtl/video_wr_sched.sv | 207 ++++++++++++++++++++
 tb/tb_video_wr_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_wr_sched.sv
// video_wr_sched: write-port scheduler for Video_Mem.
// Shares the single Video_Mem write port between two sources:
//   - Core video writes, which cannot be stalled. They are buffered in a
//     small FIFO while the port is busy (vm_ready low).
//   - A rectangle/screen fill engine, which is served only when no core
//     write is waiting.
// The memory-side outputs vm_we/vm_addr/vm_data form one registered slot.
// Optional build macro: VIDEO_WR_STATS_EN adds stat_core/stat_fill/stat_drop.
module video_wr_sched #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             core_we,
   input  logic [31:0]      core_addr,
   input  logic [31:0]      core_data,
   input  logic             fill_start,
   input  logic [31:0]      fill_base,
   input  logic [CNT_W-1:0] fill_count,
   input  logic [31:0]      fill_data,
   output logic             fill_busy,
   output logic             fill_done,
   output logic             vm_we,
   output logic [31:0]      vm_addr,
   output logic [31:0]      vm_data,
   input  logic             vm_ready,
   output logic             ovf
`ifdef VIDEO_WR_STATS_EN
   ,
   output logic [31:0]      stat_core,
   output logic [31:0]      stat_fill,
   output logic [31:0]      stat_drop
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic {
      IDLE,
      RUN
   } fill_state_t;

   // Core write FIFO
   logic [31:0]      fifo_addr [DEPTH];
   logic [31:0]      fifo_data [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   // Slot tags: whether the slot holds a fill word, and whether it is the last one
   logic             slot_fill;
   logic             slot_last;

   // Fill engine state
   fill_state_t      state;
   logic [31:0]      fill_addr;
   logic [31:0]      fill_pat;
   logic [CNT_W-1:0] fill_left;

   // Scheduling decisions
   logic slot_free;
   logic consumed;
   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic bypass;
   logic fill_load;
   logic push_req;
   logic push;
   logic drop;

   // Per-cycle load arbitration: FIFO head, then core bypass, then fill
   always_comb begin
      slot_free  = !vm_we || vm_ready;
      consumed   = vm_we && vm_ready;
      fifo_empty = (count == '0);
      fifo_full  = (count == FULL_CNT);
      pop        = slot_free && !fifo_empty;
      bypass     = slot_free && fifo_empty && core_we;
      fill_load  = slot_free && fifo_empty && !core_we &&
                   (state == RUN) && (fill_left != '0);
      push_req   = core_we && !bypass;
      push       = push_req && (!fifo_full || pop);
      drop       = push_req && fifo_full && !pop;
   end

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= core_addr;
         fifo_data[wr_ptr] <= core_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output slot: load a new write when empty or being consumed, else hold
   always_ff @(posedge clk) begin
      if (rst) begin
         vm_we     <= 1'b0;
         vm_addr   <= '0;
         vm_data   <= '0;
         slot_fill <= 1'b0;
         slot_last <= 1'b0;
      end else if (pop) begin
         vm_we     <= 1'b1;
         vm_addr   <= fifo_addr[rd_ptr];
         vm_data   <= fifo_data[rd_ptr];
         slot_fill <= 1'b0;
         slot_last <= 1'b0;
      end else if (bypass) begin
         vm_we     <= 1'b1;
         vm_addr   <= core_addr;
         vm_data   <= core_data;
         slot_fill <= 1'b0;
         slot_last <= 1'b0;
      end else if (fill_load) begin
         vm_we     <= 1'b1;
         vm_addr   <= fill_addr;
         vm_data   <= fill_pat;
         slot_fill <= 1'b1;
         slot_last <= (fill_left == CNT_W'(1));
      end else if (consumed) begin
         vm_we     <= 1'b0;
      end
   end

   // Fill FSM: RUN ends only once the last fill word has left the slot
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fill_busy <= 1'b0;
         fill_done <= 1'b0;
         fill_addr <= '0;
         fill_pat  <= '0;
         fill_left <= '0;
      end else begin
         fill_done <= 1'b0;
         case (state)
            IDLE: begin
               if (fill_start) begin
                  if (fill_count == '0) begin
                     fill_done <= 1'b1;
                  end else begin
                     state     <= RUN;
                     fill_busy <= 1'b1;
                     fill_addr <= fill_base;
                     fill_pat  <= fill_data;
                     fill_left <= fill_count;
                  end
               end
            end
            RUN: begin
               if (fill_load) begin
                  fill_addr <= fill_addr + 32'd4;
                  fill_left <= fill_left - 1'b1;
               end
               if (consumed && slot_fill && slot_last) begin
                  state     <= IDLE;
                  fill_busy <= 1'b0;
                  fill_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky overflow flag on any dropped core write
   always_ff @(posedge clk) begin
      if (rst)       ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
   end

`ifdef VIDEO_WR_STATS_EN
   // Traffic counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_core <= '0;
         stat_fill <= '0;
         stat_drop <= '0;
      end else begin
         if (consumed && !slot_fill) stat_core <= stat_core + 32'd1;
         if (consumed && slot_fill)  stat_fill <= stat_fill + 32'd1;
         if (drop)                   stat_drop <= stat_drop + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_video_wr_sched.sv
// tb_video_wr_sched: directed plus randomized bench for video_wr_sched,
// checked every cycle against a queue-based reference model.
module tb_video_wr_sched;

   localparam int DEPTH = 8;
   localparam int CNT_W = 16;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             core_we;
   logic [31:0]      core_addr;
   logic [31:0]      core_data;
   logic             fill_start;
   logic [31:0]      fill_base;
   logic [CNT_W-1:0] fill_count;
   logic [31:0]      fill_data;
   logic             fill_busy;
   logic             fill_done;
   logic             vm_we;
   logic [31:0]      vm_addr;
   logic [31:0]      vm_data;
   logic             vm_ready;
   logic             ovf;
`ifdef VIDEO_WR_STATS_EN
   logic [31:0]      stat_core;
   logic [31:0]      stat_fill;
   logic [31:0]      stat_drop;
`endif

   int checks = 0;
   int failures = 0;

   // Reference model state
   wr_t         m_q[$];
   logic        m_we, m_src_fill, m_last, m_zero;
   logic [31:0] m_addr, m_data;
   logic        m_busy, m_done, m_ovf;
   logic [31:0] m_base, m_pat;
   int unsigned m_idx, m_cnt;
   logic [31:0] s_core, s_fill, s_drop;

   video_wr_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .core_we(core_we), .core_addr(core_addr), .core_data(core_data),
      .fill_start(fill_start), .fill_base(fill_base),
      .fill_count(fill_count), .fill_data(fill_data),
      .fill_busy(fill_busy), .fill_done(fill_done),
      .vm_we(vm_we), .vm_addr(vm_addr), .vm_data(vm_data),
      .vm_ready(vm_ready), .ovf(ovf)
`ifdef VIDEO_WR_STATS_EN
      , .stat_core(stat_core), .stat_fill(stat_fill), .stat_drop(stat_drop)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Next-state of the model from the rules: free slot takes the oldest
   // pending core write, else a fresh core write, else the next fill word.
   task automatic model_step();
      logic free, cons, old_busy;
      wr_t  w;
      free     = !m_we || vm_ready;
      cons     = m_we && vm_ready;
      old_busy = m_busy;
      if (rst) begin
         m_q.delete();
         m_we = 0; m_addr = '0; m_data = '0; m_src_fill = 0; m_last = 0;
         m_busy = 0; m_done = 0; m_ovf = 0; m_idx = 0; m_cnt = 0;
         s_core = '0; s_fill = '0; s_drop = '0;
         m_zero = 1;
         return;
      end
      m_zero = 0;
      if (cons) begin
         if (m_src_fill) s_fill++;
         else            s_core++;
      end
      m_done = 0;
      if (cons && m_src_fill && m_last) begin
         m_busy = 0;
         m_done = 1;
      end else if (!old_busy && fill_start) begin
         if (fill_count == 0) m_done = 1;
         else begin
            m_busy = 1; m_base = fill_base; m_pat = fill_data;
            m_cnt = fill_count; m_idx = 0;
         end
      end
      if (free) begin
         if (m_q.size() > 0) begin
            w = m_q.pop_front();
            m_we = 1; m_addr = w.a; m_data = w.d; m_src_fill = 0; m_last = 0;
            if (core_we) m_q.push_back({core_addr, core_data});
         end else if (core_we) begin
            m_we = 1; m_addr = core_addr; m_data = core_data; m_src_fill = 0; m_last = 0;
         end else if (old_busy && m_idx < m_cnt) begin
            m_we = 1; m_addr = m_base + 32'(4 * m_idx); m_data = m_pat;
            m_src_fill = 1; m_last = (m_idx + 1 == m_cnt);
            m_idx++;
         end else begin
            m_we = 0;
         end
      end else if (core_we) begin
         if (m_q.size() < DEPTH) m_q.push_back({core_addr, core_data});
         else begin
            m_ovf = 1;
            s_drop++;
         end
      end
   endtask

   // One clock: advance the model, clock the DUT, compare #1 after the edge
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check("vm_we", 32'(vm_we), 32'(m_we));
      if (m_we || m_zero) begin
         check("vm_addr", vm_addr, m_addr);
         check("vm_data", vm_data, m_data);
      end
      check("fill_busy", 32'(fill_busy), 32'(m_busy));
      check("fill_done", 32'(fill_done), 32'(m_done));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("done_vs_busy", 32'(fill_done && fill_busy), 32'd0);
`ifdef VIDEO_WR_STATS_EN
      check("stat_core", stat_core, s_core);
      check("stat_fill", stat_fill, s_fill);
      check("stat_drop", stat_drop, s_drop);
`endif
   endtask

   task automatic idle_inputs();
      core_we = 0; fill_start = 0;
   endtask

   task automatic do_reset();
      rst = 1; idle_inputs(); step(); step();
      rst = 0;
   endtask

   initial begin
      rst = 1; core_we = 0; core_addr = '0; core_data = '0;
      fill_start = 0; fill_base = '0; fill_count = '0; fill_data = '0;
      vm_ready = 1;
      m_we = 0; m_busy = 0; m_src_fill = 0; m_last = 0; m_ovf = 0;
      #1;
      do_reset();
      check("reset_vm_we", 32'(vm_we), 32'd0);
      check("reset_vm_addr", vm_addr, 32'd0);

      // Bypass
      vm_ready = 1; core_we = 1; core_addr = 32'h8000_0010; core_data = 32'hAABBCCDD;
      step();
      idle_inputs();
      check("bypass_addr", vm_addr, 32'h8000_0010);
      check("bypass_data", vm_data, 32'hAABBCCDD);
      step();
      check("bypass_drained", 32'(vm_we), 32'd0);

      // Backpressure ordering
      vm_ready = 0;
      for (int i = 1; i <= 5; i++) begin
         core_we = 1; core_addr = 32'h100 + 32'(4 * i); core_data = 32'(i);
         step();
      end
      idle_inputs();
      check("bp_hold", vm_data, 32'd1);
      vm_ready = 1;
      for (int i = 1; i <= 5; i++) begin
         check("bp_order", vm_data, 32'(i));
         step();
      end
      check("bp_ovf", 32'(ovf), 32'd0);

      // Overflow
      vm_ready = 0;
      for (int i = 1; i <= 10; i++) begin
         core_we = 1; core_addr = 32'h200 + 32'(4 * i); core_data = 32'(i);
         step();
      end
      idle_inputs();
      check("ovf_set", 32'(ovf), 32'd1);
      check("ovf_slot", vm_data, 32'd1);
      vm_ready = 1;
      for (int i = 0; i < 11; i++) step();
      check("ovf_sticky", 32'(ovf), 32'd1);
      do_reset();
      check("ovf_cleared", 32'(ovf), 32'd0);

      // Fill of three words
      vm_ready = 1; fill_start = 1; fill_base = 32'h8000_0000;
      fill_count = 3; fill_data = 32'h00FF00FF;
      step();
      fill_start = 0;
      step(); check("fill_w0", vm_addr, 32'h8000_0000);
      step(); check("fill_w1", vm_addr, 32'h8000_0004);
      step(); check("fill_w2", vm_addr, 32'h8000_0008);
      step(); check("fill_done_pulse", 32'(fill_done), 32'd1);
      check("fill_busy_low", 32'(fill_busy), 32'd0);
`ifdef VIDEO_WR_STATS_EN
      check("stat_fill3", stat_fill, 32'd3);
`endif
      step(); check("fill_done_once", 32'(fill_done), 32'd0);

      // Preemption by a core write mid-fill
      fill_start = 1; fill_base = 32'h0000_1000; fill_count = 4; fill_data = 32'h5A5A5A5A;
      step();
      fill_start = 0;
      step(); step();
      check("pre_w1", vm_addr, 32'h0000_1004);
      core_we = 1; core_addr = 32'h0000_9000; core_data = 32'h77;
      step();
      core_we = 0;
      check("pre_core", vm_data, 32'h77);
      step(); check("pre_resume", vm_addr, 32'h0000_1008);
      for (int i = 0; i < 3; i++) step();

      // Zero-length fill
      fill_start = 1; fill_count = 0;
      step();
      fill_start = 0;
      check("zero_done", 32'(fill_done), 32'd1);
      check("zero_we", 32'(vm_we), 32'd0);
      step();

      // Reset mid-fill
      fill_start = 1; fill_base = 32'h0000_2000; fill_count = 6;
      step();
      fill_start = 0;
      step(); step();
      rst = 1; step();
      check("rst_fill_busy", 32'(fill_busy), 32'd0);
      check("rst_vm_we", 32'(vm_we), 32'd0);
      rst = 0; step();
      check("rst_no_done", 32'(fill_done), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom_range(0, 199) == 0);
         vm_ready   = ($urandom_range(0, 9) < 6);
         core_we    = ($urandom_range(0, 9) < 4);
         core_addr  = $urandom;
         core_data  = $urandom;
         fill_start = ($urandom_range(0, 19) == 0);
         fill_base  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
         fill_count = CNT_W'($urandom_range(0, 6));
         fill_data  = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
